pipe_ctrl: RTL
==============

# pipe_ctrl

Parametrised pipeline control unit for the CPU core: merges any number of per-stage stall requests into a thermometer stall bus, marks the bubble-insertion stage, and sequences registered pipeline flushes with a redirect PC. It also masks stale stall requests for a programmable drain window after each flush and runs a stall watchdog. It sits beside the stage registers, driving their `stall`/`flush` inputs and the IF redirect path.

## Interface
- `STAGES`, default 6: pipeline stages; width of the stall and bubble buses (stage 0 = PC/IF).
- `NREQ`, default 2: number of stall request sources.
- `LW`, default 3: width of one level field; must satisfy 2^LW > STAGES.
- `REQ_LEVEL`, default {3'd4, 3'd3}: packed NREQ×LW. Field i is the number of low stages frozen by source i (source 0 = ID → 3, source 1 = EX → 4). Each field is 1..STAGES.
- `PC_W`, default 32: redirect PC width.
- `DRAIN`, default 1: cycles after the flush pulse during which stall requests are ignored (0 allowed).
- `WDOG`, default 1023: consecutive stalled cycles before timeout (≥1).
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall_req`  in  NREQ  per-source stall request; level-sensitive, active-high.
- `flush_req`  in  1  flush request (exception or redirect); single-cycle or held.
- `flush_pc`  in  PC_W  redirect target, sampled with `flush_req`.
- `stall`  out  STAGES  thermometer stall bus, bit k = freeze stage k.
- `bubble`  out  STAGES  one-hot or zero; bit k = stage k loads a bubble.
- `flush`  out  1  registered flush pulse to all stage registers.
- `new_pc`  out  PC_W  registered redirect PC, valid while `flush`=1.
- `stall_timeout`  out  1  sticky watchdog flag.

## Operation
- Effective level L = max of REQ_LEVEL[i] over all i with `stall_req[i]`=1 and not masked. L=0 if there are none.
- `stall[k]` = (k < L). Resulting codes: ID-only 000111, EX 001111, both 001111.
- `bubble[L]`=1 when 0<L<STAGES; otherwise `bubble` = 0.
- Stall and bubble are combinational from `stall_req` and FSM state.
- FSM states:
  - IDLE: `flush_req`=1 → FLUSH, registering `flush_pc` into `new_pc`.
  - FLUSH (1 cycle): `flush`=1. `stall_req` is masked, so stall=0 and bubble=0. Exit to DRAIN if DRAIN>0, else IDLE.
  - DRAIN (DRAIN cycles, down-counter): `stall_req` masked, `flush`=0. Exit to IDLE when the counter expires.
- `flush_req` in any state, including FLUSH and DRAIN, re-enters FLUSH next cycle with the new `flush_pc`. The drain counter restarts.
- In the cycle `flush_req` is first asserted from IDLE, the stall outputs still reflect `stall_req`; the flush takes effect one cycle later.
- Watchdog counter, width clog2(WDOG+1), saturating:
  - +1 each cycle that `stall` ≠ 0; cleared on any cycle that `stall` = 0.
  - `stall_timeout` is set when the count reaches WDOG and stays set until reset.
- `new_pc` holds its last value outside FLUSH.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, drain counter 0, `flush`=0, `new_pc`=0, watchdog 0, `stall_timeout`=0. `stall` and `bubble` are 0 for the whole time reset is asserted, regardless of `stall_req`.
- Reset deasserted mid-FLUSH or mid-DRAIN: IDLE on the next edge; no residual flush pulse.
- Stall latency: 0 cycles (combinational). Flush latency: 1 cycle from the `flush_req` edge.
- A held `flush_req` produces `flush`=1 on every cycle it is held, plus one; DRAIN starts only after the release.
- Watchdog: with constant stall from cycle 0, `stall_timeout` rises at the edge ending stalled cycle WDOG.

## Test plan
- Reset and default mapping: pulse `rst` low with `stall_req`=2'b11 → all outputs 0. Release, `stall_req`=01 → stall 000111, bubble 001000. `stall_req`=10 or 11 → stall 001111, bubble 010000.
- Flush sequencing: in IDLE, `flush_req` for 1 cycle with `flush_pc`=0xBFC00380, `stall_req`=01 held.
  - Request cycle: stall 000111.
  - Next cycle: `flush`=1, `new_pc`=0xBFC00380, stall 0.
  - DRAIN cycle: stall 0.
  - Following cycle: stall 000111.
- Back-to-back flush: `flush_req` in FLUSH with pc 0x100, then in DRAIN with pc 0x200 → two consecutive flush pulses carrying 0x100 then 0x200. The drain counter restarts after the second pulse.
- Parameter sweep: STAGES=8, NREQ=3, LW=4, REQ_LEVEL={4'd8,4'd5,4'd2}, DRAIN=0.
  - `stall_req`=100 → stall 8'hFF, bubble 0.
  - `stall_req`=011 → stall 8'h1F, bubble 8'h20.
  - A flush returns to IDLE directly after the pulse.
- Watchdog: WDOG=4, constant stall → `stall_timeout` rises after 4 stalled cycles.
  - A 3-stall / 1-free pattern never trips it.
  - After a trip, `stall_timeout` stays 1 once stalls clear, until `rst`=0.
- Async reset mid-DRAIN: assert `rst` between edges → FSM idles immediately, and after release `stall_req` is honoured on the first cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline stall/bubble merge, flush sequencing with redirect PC,
//            post-flush stall drain window and stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int                 STAGES    = 6,
    parameter int                 NREQ      = 2,
    parameter int                 LW        = 3,
    parameter logic [NREQ*LW-1:0] REQ_LEVEL = {3'd4, 3'd3},
    parameter int                 PC_W      = 32,
    parameter int                 DRAIN     = 1,
    parameter int                 WDOG      = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stall_req,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   flush_pc,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic              flush,
    output logic [PC_W-1:0]   new_pc,
    output logic              stall_timeout
);

    localparam int c_DRAIN_W = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;
    localparam int c_WD_W    = $clog2(WDOG + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FLUSH = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic [c_DRAIN_W-1:0] w_drain_nxt;
    logic [PC_W-1:0]      r_new_pc;
    logic [c_WD_W-1:0]    r_wdog_cnt;
    logic [c_WD_W-1:0]    w_wdog_nxt;
    logic                 r_timeout;
    logic                 w_mask;
    logic [LW-1:0]        w_level;

    // Requests are ignored outside IDLE and while reset is held low.
    assign w_mask = (r_state != c_IDLE) || !rst;

    always_comb begin
        w_level = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stall_req[i] && !w_mask && (REQ_LEVEL[i*LW +: LW] > w_level)) begin
                w_level = REQ_LEVEL[i*LW +: LW];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_bus
        assign stall[k] = (w_level > LW'(k));
        if (k == 0) begin : g_first
            assign bubble[k] = 1'b0;
        end else begin : g_rest
            assign bubble[k] = (w_level == LW'(k));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        if (flush_req) begin
            w_state_nxt = c_FLUSH;
            w_drain_nxt = '0;
        end else begin
            case (r_state)
                c_FLUSH: begin
                    if (DRAIN > 0) begin
                        w_state_nxt = c_DRAIN;
                        w_drain_nxt = c_DRAIN_W'(DRAIN);
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
                c_DRAIN: begin
                    if (r_drain_cnt <= c_DRAIN_W'(1)) begin
                        w_state_nxt = c_IDLE;
                        w_drain_nxt = '0;
                    end else begin
                        w_drain_nxt = r_drain_cnt - c_DRAIN_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_wdog_nxt = r_wdog_cnt;
        if (stall == '0) begin
            w_wdog_nxt = '0;
        end else if (r_wdog_cnt != c_WD_W'(WDOG)) begin
            w_wdog_nxt = r_wdog_cnt + c_WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_drain_cnt <= '0;
            r_new_pc    <= '0;
            r_wdog_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_wdog_cnt  <= w_wdog_nxt;
            r_timeout   <= r_timeout | (w_wdog_nxt == c_WD_W'(WDOG));
            if (flush_req) begin
                r_new_pc <= flush_pc;
            end
        end
    end

    assign flush         = (r_state == c_FLUSH);
    assign new_pc        = r_new_pc;
    assign stall_timeout = r_timeout;

endmodule

`default_nettype wire
